// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet TX payload constants and types
package eth_pkg;
   localparam int ETH_MIN_PAYLOAD = 46;
   localparam int ETH_MAX_PAYLOAD = 1500;

   typedef logic [10:0] eth_len_t;

   typedef enum logic [2:0] {
      FILL,
      DISCARD,
      PAD,
      DRAIN,
      KICK,
      WAIT_START,
      WAIT_END
   } tx_buf_state_t;
endpackage

// File: rtl/eth_sdp_ram.sv
// rtl/eth_sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module eth_sdp_ram #(
   parameter int DEPTH = 1500,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];

   // No reset so the array maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end
endmodule

// File: rtl/eth_tx_pkt_buf.sv
// rtl/eth_tx_pkt_buf.sv - single-packet payload buffer feeding eth_tx
// Stores one payload, pads/truncates it, replays it as a contiguous burst and tracks Tx_En.
module eth_tx_pkt_buf
   import eth_pkg::*;
#(
   parameter int MIN_PAYLOAD = ETH_MIN_PAYLOAD,
   parameter int MAX_PAYLOAD = ETH_MAX_PAYLOAD,
   parameter int TX_TIMEOUT  = 1024
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [7:0] S_Byte,
   input  logic       S_Valid,
   input  logic       S_Last,
   output logic       S_Ready,
   output logic [7:0] Eth_Byte,
   output logic       Eth_Byte_Valid,
   output logic       Eth_Pkt_Rdy,
   input  logic       Tx_En,
   output logic       Busy,
   output logic       Pkt_Sent,
   output logic       Trunc_Err,
   output logic       Tx_Timeout
);
   localparam int AW = $clog2(MAX_PAYLOAD);
   localparam int TW = $clog2(TX_TIMEOUT);
   localparam eth_len_t      MIN_LEN  = eth_len_t'(MIN_PAYLOAD);
   localparam eth_len_t      MAX_LEN  = eth_len_t'(MAX_PAYLOAD);
   localparam logic [TW-1:0] TMO_LAST = TW'(TX_TIMEOUT - 1);

   tx_buf_state_t state_q, state_d;
   eth_len_t      len_q, len_d;
   eth_len_t      rd_ptr_q, rd_ptr_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          valid_q, tx_en_q;
   logic          ready, we, re;
   logic [7:0]    wdata, rdata;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q  <= FILL;
         len_q    <= '0;
         rd_ptr_q <= '0;
         timer_q  <= '0;
         valid_q  <= 1'b0;
         tx_en_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         rd_ptr_q <= rd_ptr_d;
         timer_q  <= timer_d;
         valid_q  <= re;
         tx_en_q  <= Tx_En;
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      rd_ptr_d    = rd_ptr_q;
      timer_d     = timer_q;
      ready       = 1'b0;
      we          = 1'b0;
      wdata       = S_Byte;
      re          = 1'b0;
      Eth_Pkt_Rdy = 1'b0;
      Pkt_Sent    = 1'b0;
      Trunc_Err   = 1'b0;
      Tx_Timeout  = 1'b0;
      case (state_q)
         FILL: begin
            ready = 1'b1;
            if (S_Valid) begin
               we    = 1'b1;
               len_d = len_q + 1'b1;
               if (S_Last) begin
                  state_d = (len_d < MIN_LEN) ? PAD : DRAIN;
               end else if (len_d == MAX_LEN) begin
                  Trunc_Err = 1'b1;
                  state_d   = DISCARD;
               end
            end
         end
         DISCARD: begin
            ready = 1'b1;
            if (S_Valid && S_Last) state_d = DRAIN;
         end
         PAD: begin
            we    = 1'b1;
            wdata = 8'h00;
            len_d = len_q + 1'b1;
            if (len_d == MIN_LEN) state_d = DRAIN;
         end
         DRAIN: begin
            // One extra cycle after the last read lets the final byte surface before KICK.
            if (rd_ptr_q < len_q) begin
               re       = 1'b1;
               rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
               state_d = KICK;
            end
         end
         KICK: begin
            Eth_Pkt_Rdy = 1'b1;
            timer_d     = '0;
            rd_ptr_d    = '0;
            state_d     = WAIT_START;
         end
         WAIT_START: begin
            if (Tx_En) begin
               state_d = WAIT_END;
            end else if (timer_q == TMO_LAST) begin
               Tx_Timeout = 1'b1;
               len_d      = '0;
               rd_ptr_d   = '0;
               state_d    = FILL;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         WAIT_END: begin
            if (tx_en_q && !Tx_En) begin
               Pkt_Sent = 1'b1;
               len_d    = '0;
               rd_ptr_d = '0;
               state_d  = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // The write address is the running length; the packet always starts at address 0.
   eth_sdp_ram #(
      .DEPTH (MAX_PAYLOAD),
      .WIDTH (8),
      .AW    (AW)
   ) u_ram (
      .clk_i   (Clk),
      .we_i    (we),
      .waddr_i (len_q[AW-1:0]),
      .wdata_i (wdata),
      .re_i    (re),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rdata)
   );

   assign S_Ready        = ready && !Rst;
   assign Eth_Byte_Valid = valid_q;
   assign Eth_Byte       = valid_q ? rdata : 8'h00;
   assign Busy           = (state_q != FILL);
endmodule

// File: tb/tb_eth_tx_pkt_buf.sv
// tb/tb_eth_tx_pkt_buf.sv - self-checking bench for eth_tx_pkt_buf
module tb_eth_tx_pkt_buf;
   localparam int MIN_P = 46;
   localparam int MAX_P = 1500;
   localparam int TMO   = 64;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic [7:0] S_Byte = 8'h00;
   logic       S_Valid = 1'b0;
   logic       S_Last = 1'b0;
   logic       S_Ready;
   logic [7:0] Eth_Byte;
   logic       Eth_Byte_Valid;
   logic       Eth_Pkt_Rdy;
   logic       Tx_En = 1'b0;
   logic       Busy;
   logic       Pkt_Sent;
   logic       Trunc_Err;
   logic       Tx_Timeout;

   eth_tx_pkt_buf #(
      .MIN_PAYLOAD (MIN_P),
      .MAX_PAYLOAD (MAX_P),
      .TX_TIMEOUT  (TMO)
   ) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .S_Byte         (S_Byte),
      .S_Valid        (S_Valid),
      .S_Last         (S_Last),
      .S_Ready        (S_Ready),
      .Eth_Byte       (Eth_Byte),
      .Eth_Byte_Valid (Eth_Byte_Valid),
      .Eth_Pkt_Rdy    (Eth_Pkt_Rdy),
      .Tx_En          (Tx_En),
      .Busy           (Busy),
      .Pkt_Sent       (Pkt_Sent),
      .Trunc_Err      (Trunc_Err),
      .Tx_Timeout     (Tx_Timeout)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Output-side monitor state.
   logic [7:0] out_q[$];
   int cyc = 0, first_v = 0, last_v = 0, last_acc = 0;
   int kick_cnt = 0, kick_cyc = 0, sent_cnt = 0, tmo_cnt = 0, tmo_cyc = 0;
   int trunc_cnt = 0, trunc_idx = 0, acc_total = 0;
   int zero_err = 0, busy_err = 0;
   bit prev_v = 0, busy_exp = 0;

   always @(negedge Clk) begin
      cyc++;
      if (!Rst) begin
         if (Eth_Byte_Valid) begin
            if (!prev_v) first_v = cyc;
            out_q.push_back(Eth_Byte);
            last_v = cyc;
         end else if (Eth_Byte != 8'h00) begin
            zero_err++;
         end
         prev_v = Eth_Byte_Valid;
         if (busy_exp && !Busy) busy_err++;
         if (S_Valid && S_Ready) begin
            if (Trunc_Err) begin
               trunc_cnt++;
               trunc_idx = acc_total + 1;
            end
            acc_total++;
            last_acc = cyc;
            if (S_Last) busy_exp = 1;
         end else if (Trunc_Err) begin
            trunc_cnt++;
         end
         if (Eth_Pkt_Rdy) begin
            kick_cnt++;
            kick_cyc = cyc;
         end
         if (Pkt_Sent) begin
            sent_cnt++;
            busy_exp = 0;
         end
         if (Tx_Timeout) begin
            tmo_cnt++;
            tmo_cyc = cyc;
            busy_exp = 0;
         end
      end else begin
         prev_v = 0;
         busy_exp = 0;
      end
   end

   task automatic clear_mon();
      out_q.delete();
      first_v = 0; last_v = 0; last_acc = 0;
      kick_cnt = 0; kick_cyc = 0; sent_cnt = 0; tmo_cnt = 0; tmo_cyc = 0;
      trunc_cnt = 0; trunc_idx = 0; acc_total = 0; zero_err = 0; busy_err = 0;
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_pkt(input logic [7:0] data[$], input int gap_pct, input bit hold_valid,
                            output bit stuck);
      stuck = 0;
      for (int i = 0; i < data.size(); i++) begin
         while ($urandom_range(99) < gap_pct) begin
            S_Valid = 1'b0;
            step();
         end
         S_Valid = 1'b1;
         S_Byte  = data[i];
         S_Last  = (i == data.size() - 1);
         begin : wait_acc
            for (int w = 0; w < 5000; w++) begin
               @(negedge Clk);
               if (S_Ready) begin
                  step();
                  disable wait_acc;
               end
            end
            stuck = 1;
         end
         if (stuck) break;
      end
      S_Valid = hold_valid;
      S_Byte  = 8'h55;
      S_Last  = 1'b0;
   endtask

   // Expected burst: first MAX_P bytes of the payload, zero-padded up to MIN_P.
   task automatic run_pkt(input string name, input logic [7:0] data[$], input int gap_pct,
                          input bit tmo_mode, input bit hold_valid);
      logic [7:0] exp_q[$];
      int n, nbad, pad;
      bit stuck;
      n = data.size();
      for (int i = 0; i < n && i < MAX_P; i++) exp_q.push_back(data[i]);
      while (exp_q.size() < MIN_P) exp_q.push_back(8'h00);
      pad = (n < MIN_P) ? MIN_P - n : 0;

      clear_mon();
      drive_pkt(data, gap_pct, hold_valid, stuck);
      check({name, ".src_stuck"}, stuck, 0);
      for (int w = 0; w < 4000 && kick_cnt == 0; w++) step();
      check({name, ".kick_seen"}, kick_cnt, 1);

      if (!tmo_mode) begin
         repeat (4) step();
         Tx_En = 1'b1;
         repeat (100) step();
         Tx_En = 1'b0;
         for (int w = 0; w < 50 && sent_cnt == 0; w++) step();
         check({name, ".sent"}, sent_cnt, 1);
         S_Valid = 1'b0;
         check({name, ".tmo_none"}, tmo_cnt, 0);
         check({name, ".acc"}, acc_total, n);
      end else begin
         for (int w = 0; w < 200 && tmo_cnt == 0; w++) step();
         check({name, ".tmo"}, tmo_cnt, 1);
         check({name, ".tmo_lat"}, tmo_cyc - kick_cyc, TMO);
         check({name, ".sent_none"}, sent_cnt, 0);
      end
      @(negedge Clk);
      check({name, ".busy_after"}, Busy, 0);
      check({name, ".ready_after"}, S_Ready, 1);

      check({name, ".len"}, out_q.size(), exp_q.size());
      nbad = 0;
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
         if (out_q[i] !== exp_q[i]) nbad++;
      check({name, ".data_bad"}, nbad, 0);
      check({name, ".contig"}, last_v - first_v + 1, exp_q.size());
      check({name, ".drain_lat"}, first_v - last_acc, 2 + pad);
      check({name, ".kick_lat"}, kick_cyc - last_v, 1);
      check({name, ".trunc_cnt"}, trunc_cnt, (n > MAX_P) ? 1 : 0);
      if (n > MAX_P) check({name, ".trunc_idx"}, trunc_idx, MAX_P);
      check({name, ".zero_idle"}, zero_err, 0);
      check({name, ".busy_hold"}, busy_err, 0);
      step();
   endtask

   function automatic logic [15:0] all_outs();
      return {S_Ready, Eth_Byte_Valid, Eth_Pkt_Rdy, Busy, Pkt_Sent, Trunc_Err, Tx_Timeout,
              1'b0, Eth_Byte};
   endfunction

   initial begin
      logic [7:0] d[$];
      int lens[3];

      #2;
      check("rst.outs", all_outs(), 0);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
      check("rst.ready", S_Ready, 1);
      check("rst.busy", Busy, 0);
      step();

      d = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_pkt("t1_short", d, 0, 0, 0);

      d.delete();
      for (int i = 0; i < 60; i++) d.push_back(8'(i));
      run_pkt("t2_gaps", d, 30, 0, 0);

      d.delete();
      for (int i = 0; i < 1600; i++) d.push_back(8'($urandom));
      run_pkt("t3_trunc", d, 10, 0, 0);

      d.delete();
      for (int i = 0; i < 46; i++) d.push_back(8'($urandom));
      run_pkt("t4_tmo", d, 0, 1, 0);
      d.delete();
      for (int i = 0; i < 46; i++) d.push_back(8'($urandom));
      run_pkt("t4_after", d, 20, 0, 0);

      clear_mon();
      for (int i = 0; i < 10; i++) begin
         S_Valid = 1'b1;
         S_Byte  = 8'($urandom);
         S_Last  = 1'b0;
         step();
      end
      S_Valid = 1'b0;
      #2 Rst = 1'b1;
      #1 check("t5.outs_in_rst", all_outs(), 0);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      clear_mon();
      repeat (20) step();
      check("t5.no_bytes", out_q.size(), 0);
      check("t5.no_kick", kick_cnt, 0);
      d.delete();
      for (int i = 0; i < 50; i++) d.push_back(8'($urandom));
      run_pkt("t5_after", d, 15, 0, 0);

      d = '{8'hAA};
      run_pkt("t6_single", d, 0, 0, 1);

      lens = '{MIN_P - 1, MAX_P, MAX_P + 1};
      foreach (lens[k]) begin
         d.delete();
         for (int i = 0; i < lens[k]; i++) d.push_back(8'($urandom));
         run_pkt($sformatf("bnd_%0d", lens[k]), d, 5, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
